// File: rtl/minisys_pkg.sv
// Shared Minisys definitions: opcode/funct encodings, destination-select codes and the
// control bundle carried from ID into EX.
package minisys_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  typedef struct packed {
    logic       regwr;
    logic       memrd;
    logic       memwr;
    logic       alusrc;
    logic       branch;
    logic       jump;
    logic [1:0] regdst;
  } ctrl_t;

endpackage

// File: rtl/minisys_regfile.sv
// 32x32 register file, two combinational read ports, one posedge write port; r0 hardwired to 0.
// MINISYS_ID_WB_BYPASS_EN: same-cycle write-through from the write port to matching read ports.
module minisys_regfile #(
  parameter int REG_NUM = 32
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] regs [REG_NUM];
  logic [31:0] raw1, raw2;
  logic        wr_en;

  assign wr_en = we && (wa != 5'd0);

  // clr wins over a write arriving in the same cycle
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wa] <= wd;
    end
  end

  assign raw1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
  assign raw2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];

`ifdef MINISYS_ID_WB_BYPASS_EN
  assign rd1 = (wr_en && (wa == ra1)) ? wd : raw1;
  assign rd2 = (wr_en && (wa == ra2)) ? wd : raw2;
`else
  assign rd1 = raw1;
  assign rd2 = raw2;
`endif

endmodule

// File: rtl/minisys_id.sv
// Minisys ID stage: decode, register read, load-use stall and ID/EX register (1-cycle latency).
// stall_req is combinational; MINISYS_ID_WB_BYPASS_EN selects write-through reads in the regfile.
module minisys_id
  import minisys_pkg::*;
#(
  parameter int          REG_NUM   = 32,
  parameter logic [31:0] RESET_PC4 = 32'h0000_0004
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] instrD,
  input  logic [31:0] pcplus4D,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        flush,
  output logic        stall_req,
  output logic [31:0] pcplus4E,
  output logic [31:0] rd1E,
  output logic [31:0] rd2E,
  output logic [31:0] imm32E,
  output logic [4:0]  rsE,
  output logic [4:0]  rtE,
  output logic [4:0]  rdE,
  output logic [4:0]  shamtE,
  output logic [5:0]  functE,
  output logic        regwrE,
  output logic        memrdE,
  output logic        memwrE,
  output logic        alusrcE,
  output logic        branchE,
  output logic        jumpE,
  output logic [1:0]  regdstE
);

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt;
  logic [15:0] imm16;
  logic [31:0] rd1, rd2, imm32;
  ctrl_t       ctrl;
  logic        reads_rt;

  assign op    = instrD[31:26];
  assign rs    = instrD[25:21];
  assign rt    = instrD[20:16];
  assign imm16 = instrD[15:0];
  assign funct = instrD[5:0];

  minisys_regfile #(.REG_NUM(REG_NUM)) u_regfile (
    .clk (clk),
    .clr (clr),
    .ra1 (rs),
    .ra2 (rt),
    .rd1 (rd1),
    .rd2 (rd2),
    .we  (wb_we),
    .wa  (wb_addr),
    .wd  (wb_data)
  );

  always_comb begin
    ctrl     = '0;
    reads_rt = 1'b0;
    imm32    = {{16{imm16[15]}}, imm16};
    case (op)
      OP_RTYPE: begin
        reads_rt    = 1'b1;
        ctrl.regdst = REGDST_RD;
        if (funct == FN_JR) ctrl.jump  = 1'b1;
        else                ctrl.regwr = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        ctrl.regwr  = 1'b1;
        ctrl.alusrc = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        ctrl.regwr  = 1'b1;
        ctrl.alusrc = 1'b1;
        imm32       = {16'd0, imm16};
      end
      OP_LUI: begin
        ctrl.regwr  = 1'b1;
        ctrl.alusrc = 1'b1;
        imm32       = {imm16, 16'd0};
      end
      OP_LW: begin
        ctrl.regwr  = 1'b1;
        ctrl.memrd  = 1'b1;
        ctrl.alusrc = 1'b1;
      end
      OP_SW: begin
        reads_rt    = 1'b1;
        ctrl.memwr  = 1'b1;
        ctrl.alusrc = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        reads_rt    = 1'b1;
        ctrl.branch = 1'b1;
      end
      OP_J: ctrl.jump = 1'b1;
      OP_JAL: begin
        ctrl.jump   = 1'b1;
        ctrl.regwr  = 1'b1;
        ctrl.regdst = REGDST_RA;
      end
      default: ;
    endcase
  end

  // Only a load in EX can produce data too late for EX-stage forwarding.
  assign stall_req = memrdE && (rtE != 5'd0) &&
                     ((rtE == rs) || ((rtE == rt) && reads_rt));

  always_ff @(posedge clk) begin
    if (clr) begin
      pcplus4E <= RESET_PC4;
      rd1E     <= '0;
      rd2E     <= '0;
      imm32E   <= '0;
      rsE      <= '0;
      rtE      <= '0;
      rdE      <= '0;
      shamtE   <= '0;
      functE   <= '0;
      regwrE   <= 1'b0;
      memrdE   <= 1'b0;
      memwrE   <= 1'b0;
      alusrcE  <= 1'b0;
      branchE  <= 1'b0;
      jumpE    <= 1'b0;
      regdstE  <= REGDST_RT;
    end else begin
      pcplus4E <= pcplus4D;
      rd1E     <= rd1;
      rd2E     <= rd2;
      imm32E   <= imm32;
      rsE      <= rs;
      rtE      <= rt;
      rdE      <= instrD[15:11];
      shamtE   <= instrD[10:6];
      functE   <= funct;
      if (flush || stall_req) begin
        regwrE  <= 1'b0;
        memrdE  <= 1'b0;
        memwrE  <= 1'b0;
        alusrcE <= 1'b0;
        branchE <= 1'b0;
        jumpE   <= 1'b0;
        regdstE <= REGDST_RT;
      end else begin
        regwrE  <= ctrl.regwr;
        memrdE  <= ctrl.memrd;
        memwrE  <= ctrl.memwr;
        alusrcE <= ctrl.alusrc;
        branchE <= ctrl.branch;
        jumpE   <= ctrl.jump;
        regdstE <= ctrl.regdst;
      end
    end
  end

endmodule

// File: tb/tb_minisys_id.sv
// Bench for minisys_id: directed literal checks, then random traffic against a behavioural model.
module tb_minisys_id;

  localparam logic [5:0] T_R = 6'h00, T_J = 6'h02, T_JAL = 6'h03, T_BEQ = 6'h04, T_BNE = 6'h05;
  localparam logic [5:0] T_ADDI = 6'h08, T_ADDIU = 6'h09, T_SLTI = 6'h0A, T_SLTIU = 6'h0B;
  localparam logic [5:0] T_ANDI = 6'h0C, T_ORI = 6'h0D, T_XORI = 6'h0E, T_LUI = 6'h0F;
  localparam logic [5:0] T_LW = 6'h23, T_SW = 6'h2B;

  logic        clk = 1'b0;
  logic        clr, wb_we, flush;
  logic [31:0] instrD, pcplus4D, wb_data;
  logic [4:0]  wb_addr;
  logic        stall_req;
  logic [31:0] pcplus4E, rd1E, rd2E, imm32E;
  logic [4:0]  rsE, rtE, rdE, shamtE;
  logic [5:0]  functE;
  logic        regwrE, memrdE, memwrE, alusrcE, branchE, jumpE;
  logic [1:0]  regdstE;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  minisys_id dut (
    .clk(clk), .clr(clr), .instrD(instrD), .pcplus4D(pcplus4D),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
    .stall_req(stall_req), .pcplus4E(pcplus4E), .rd1E(rd1E), .rd2E(rd2E),
    .imm32E(imm32E), .rsE(rsE), .rtE(rtE), .rdE(rdE), .shamtE(shamtE),
    .functE(functE), .regwrE(regwrE), .memrdE(memrdE), .memwrE(memwrE),
    .alusrcE(alusrcE), .branchE(branchE), .jumpE(jumpE), .regdstE(regdstE)
  );

  typedef struct {
    logic [31:0] pc4, rd1, rd2, imm;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fn;
    logic        regwr, memrd, memwr, alusrc, branch, jump;
    logic [1:0]  regdst;
  } idex_t;

  idex_t       e;
  logic [31:0] mregs [32];
  logic [5:0]  m_op, m_fn;
  logic [4:0]  m_rs, m_rt;
  logic [7:0]  m_ctl;
  logic        m_stall, m_reads_rt;
  logic [31:0] a1, a2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {T_R, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // {regwr, memrd, memwr, alusrc, branch, jump, regdst[1:0]} from instruction class rules
  function automatic logic [7:0] model_ctl(input logic [31:0] ins);
    logic [5:0] op;
    logic is_r, is_jr, ialu, lw, sw, br, jal, j;
    logic [1:0] dst;
    op    = ins[31:26];
    is_r  = (op == T_R);
    is_jr = is_r && (ins[5:0] == 6'h08);
    ialu  = (op inside {T_ADDI, T_ADDIU, T_ANDI, T_ORI, T_XORI, T_LUI, T_SLTI, T_SLTIU});
    lw    = (op == T_LW);
    sw    = (op == T_SW);
    br    = (op == T_BEQ) || (op == T_BNE);
    jal   = (op == T_JAL);
    j     = (op == T_J);
    dst   = is_r ? 2'd1 : (jal ? 2'd2 : 2'd0);
    return {(is_r && !is_jr) || ialu || lw || jal, lw, sw, ialu || lw || sw, br,
            j || jal || is_jr, dst};
  endfunction

  function automatic logic [31:0] model_imm(input logic [31:0] ins);
    logic [5:0] op;
    logic [15:0] im;
    op = ins[31:26];
    im = ins[15:0];
    if (op == T_ANDI || op == T_ORI || op == T_XORI) return {16'd0, im};
    if (op == T_LUI) return {im, 16'd0};
    return {{16{im[15]}}, im};
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [5:0] ops [18];
    logic [31:0] ins;
    ops = '{T_R, T_R, T_R, T_LW, T_LW, T_LW, T_SW, T_BEQ, T_BNE, T_J, T_JAL,
            T_ADDI, T_ADDIU, T_ANDI, T_ORI, T_XORI, T_LUI, 6'h3F};
    ins = $urandom;
    ins[31:26] = ops[$urandom_range(0, 17)];
    if ($urandom_range(0, 9) == 0) ins[31:26] = T_SLTIU;
    ins[25:21] = 5'($urandom_range(0, 7));
    ins[20:16] = 5'($urandom_range(0, 7));
    if (ins[31:26] == T_R && $urandom_range(0, 3) == 0) ins[5:0] = 6'h08;
    return ins;
  endfunction

  task automatic cmp_all();
    chk("pcplus4E", pcplus4E, e.pc4);
    chk("rd1E", rd1E, e.rd1);
    chk("rd2E", rd2E, e.rd2);
    chk("imm32E", imm32E, e.imm);
    chk("rsE", 32'(rsE), 32'(e.rs));
    chk("rtE", 32'(rtE), 32'(e.rt));
    chk("rdE", 32'(rdE), 32'(e.rd));
    chk("shamtE", 32'(shamtE), 32'(e.sh));
    chk("functE", 32'(functE), 32'(e.fn));
    chk("ctrl", 32'({regwrE, memrdE, memwrE, alusrcE, branchE, jumpE, regdstE}),
        32'({e.regwr, e.memrd, e.memwr, e.alusrc, e.branch, e.jump, e.regdst}));
  endtask

  task automatic model_reset();
    e = '{pc4: 32'h4, rd1: 0, rd2: 0, imm: 0, rs: 0, rt: 0, rd: 0, sh: 0, fn: 0,
          regwr: 0, memrd: 0, memwr: 0, alusrc: 0, branch: 0, jump: 0, regdst: 0};
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
  endtask

  initial begin
    clr = 1'b1; flush = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    instrD = '0; pcplus4D = '0;

    // reset
    step(); step();
    chk("rst_pc4", pcplus4E, 32'h4);
    chk("rst_ctrl", 32'({regwrE, memrdE, memwrE, alusrcE, branchE, jumpE, regdstE}), 32'd0);
    chk("rst_rd1", rd1E, 32'd0);
    clr = 1'b0;
    instrD = enc_r(5'd5, 5'd0, 5'd1, 6'h20);
    step();
    chk("read_r5", rd1E, 32'd0);
    chk("add_regwr", 32'(regwrE), 32'd1);

    // write r8 then read it
    wb_we = 1'b1; wb_addr = 5'd8; wb_data = 32'hDEAD_BEEF; instrD = '0;
    step();
    wb_we = 1'b0; instrD = enc_r(5'd8, 5'd0, 5'd9, 6'h20);
    step();
    chk("rd_r8", rd1E, 32'hDEAD_BEEF);
    chk("add_regdst", 32'(regdstE), 32'd1);
    chk("add_rdE", 32'(rdE), 32'd9);

    // writes to r0 are ignored
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234;
    step();
    wb_we = 1'b0; instrD = enc_r(5'd0, 5'd0, 5'd1, 6'h20);
    step();
    chk("r0_zero", rd1E, 32'd0);

    // immediate extension
    instrD = enc_i(T_ORI, 5'd0, 5'd1, 16'h8001); step();
    chk("imm_ori", imm32E, 32'h0000_8001);
    chk("ori_alusrc", 32'({alusrcE, regdstE}), 32'b100);
    instrD = enc_i(T_ADDI, 5'd0, 5'd1, 16'h8001); step();
    chk("imm_addi", imm32E, 32'hFFFF_8001);
    instrD = enc_i(T_LUI, 5'd0, 5'd1, 16'h1234); step();
    chk("imm_lui", imm32E, 32'h1234_0000);

    // load-use: one bubble then the add issues
    instrD = enc_i(T_LW, 5'd1, 5'd2, 16'd0); step();
    chk("lw_memrd", 32'({memrdE, rtE}), 32'({1'b1, 5'd2}));
    instrD = enc_r(5'd2, 5'd4, 5'd3, 6'h20); #1;
    chk("lu_stall", 32'(stall_req), 32'd1);
    step();
    chk("lu_bubble", 32'({regwrE, memrdE}), 32'd0);
    chk("lu_stall_gone", 32'(stall_req), 32'd0);
    step();
    chk("lu_issue", 32'({regwrE, rsE}), 32'({1'b1, 5'd2}));

    // flush squashes a store
    instrD = enc_i(T_SW, 5'd1, 5'd2, 16'd4); flush = 1'b1; step();
    chk("flush_sw", 32'(memwrE), 32'd0);
    flush = 1'b0; step();
    chk("sw_memwr", 32'(memwrE), 32'd1);

    // flush and load-use together
    instrD = enc_i(T_LW, 5'd1, 5'd2, 16'd0); step();
    instrD = enc_r(5'd2, 5'd4, 5'd3, 6'h20); flush = 1'b1; #1;
    chk("fl_lu_stall", 32'(stall_req), 32'd1);
    step();
    flush = 1'b0;
    chk("fl_lu_bubble", 32'({regwrE, memrdE}), 32'd0);

    // same-cycle write-back and read of r7
    wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h11; instrD = '0; step();
    wb_data = 32'h55; instrD = enc_r(5'd7, 5'd0, 5'd1, 6'h20); step();
    wb_we = 1'b0;
`ifdef MINISYS_ID_WB_BYPASS_EN
    chk("bypass_r7", rd1E, 32'h55);
`else
    chk("bypass_r7", rd1E, 32'h11);
`endif

    // random traffic against the model
    clr = 1'b1; step();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      cmp_all();
      clr      = ($urandom_range(0, 99) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      wb_we    = 1'($urandom_range(0, 1));
      wb_addr  = 5'($urandom_range(0, 7));
      wb_data  = $urandom;
      pcplus4D = $urandom;
      instrD   = gen_instr();
      #1;
      m_op = instrD[31:26]; m_fn = instrD[5:0];
      m_rs = instrD[25:21]; m_rt = instrD[20:16];
      m_reads_rt = (m_op == T_R) || (m_op == T_BEQ) || (m_op == T_BNE) || (m_op == T_SW);
      m_stall = e.memrd && (e.rt != 0) && ((e.rt == m_rs) || ((e.rt == m_rt) && m_reads_rt));
      chk("stall_req", 32'(stall_req), 32'(m_stall));
      if (clr) begin
        model_reset();
      end else begin
        a1 = mregs[m_rs];
        a2 = mregs[m_rt];
`ifdef MINISYS_ID_WB_BYPASS_EN
        if (wb_we && wb_addr != 0 && wb_addr == m_rs) a1 = wb_data;
        if (wb_we && wb_addr != 0 && wb_addr == m_rt) a2 = wb_data;
`endif
        m_ctl = (flush || m_stall) ? 8'd0 : model_ctl(instrD);
        e.pc4 = pcplus4D; e.rd1 = a1; e.rd2 = a2; e.imm = model_imm(instrD);
        e.rs = m_rs; e.rt = m_rt; e.rd = instrD[15:11]; e.sh = instrD[10:6]; e.fn = m_fn;
        {e.regwr, e.memrd, e.memwr, e.alusrc, e.branch, e.jump, e.regdst} = m_ctl;
        if (wb_we && wb_addr != 0) mregs[wb_addr] = wb_data;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
